// File: rtl/jlc3_mem_arb_pkg.sv
// Shared encodings for the jlc3 memory-port arbiter: FSM states and owner IDs.
package jlc3_mem_arb_pkg;

  typedef enum logic [1:0] {
    arb_sta_idle   = 2'd0,
    arb_sta_access = 2'd1,
    arb_sta_done   = 2'd2
  } arb_sta_e;

  localparam logic arb_own_if = 1'b0;
  localparam logic arb_own_dm = 1'b1;

endpackage

// File: rtl/jlc3_mem_arb_wdog.sv
// ACCESS-state watchdog: down-counter reloaded while clear is high, expires
// during the TIMEOUT_CYC-th enabled cycle.
module jlc3_mem_arb_wdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD_C = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD_C;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= LOAD_C;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/jlc3_mem_arb.sv
// Round-robin arbiter/sequencer for the shared memory port (fetch vs data).
// Optional ACCESS timeout abort is enabled with `JLC3_MEM_ARB_TIMEOUT_EN.
module jlc3_mem_arb
  import jlc3_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk_i_w,
  input  logic              rst_i_w,
  input  logic              if_req_i_w,
  input  logic [ADDR_W-1:0] if_addr_i_w,
  output logic              if_done_o_r,
  input  logic              dm_req_i_w,
  input  logic [ADDR_W-1:0] dm_addr_i_w,
  input  logic              dm_we_i_w,
  input  logic [DATA_W-1:0] dm_wdat_i_w,
  output logic              dm_done_o_r,
  output logic [DATA_W-1:0] rdat_o_r,
  output logic              busy_o_r,
  output logic              err_o_r,
  output logic              mem_req_o_r,
  output logic [ADDR_W-1:0] mem_addr_o_r,
  output logic              mem_we_o_r,
  output logic [DATA_W-1:0] mem_wdat_o_r,
  input  logic [DATA_W-1:0] mem_rdat_i_w,
  input  logic              mem_rdy_i_w
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  arb_sta_e          state_q, state_d;
  logic              own_q, own_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              mem_req_q, mem_req_d;
  logic              busy_q, busy_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic              err_q, err_d;
  logic              grant_dm;
  logic              expire_w;

`ifdef JLC3_MEM_ARB_TIMEOUT_EN
  jlc3_mem_arb_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk_i   (clk_i_w),
    .rst_i   (rst_i_w),
    .clr_i   (state_q != arb_sta_access),
    .en_i    (state_q == arb_sta_access),
    .expire_o(expire_w)
  );
`else
  assign expire_w = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    last_d    = last_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    mem_req_d = mem_req_q;
    busy_d    = busy_q;
    if_done_d = 1'b0;
    dm_done_d = 1'b0;
    err_d     = 1'b0;
    grant_dm  = 1'b0;
    case (state_q)
      arb_sta_idle: begin
        if (if_req_i_w || dm_req_i_w) begin
          // On a tie the requester not served last wins.
          grant_dm  = dm_req_i_w && (!if_req_i_w || (last_q == arb_own_if));
          own_d     = grant_dm ? arb_own_dm : arb_own_if;
          addr_d    = grant_dm ? dm_addr_i_w : if_addr_i_w;
          we_d      = grant_dm && dm_we_i_w;
          wdat_d    = grant_dm ? dm_wdat_i_w : '0;
          mem_req_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = arb_sta_access;
        end
      end
      arb_sta_access: begin
        if (mem_rdy_i_w) begin
          if (!we_q) rdat_d = mem_rdat_i_w;
          mem_req_d = 1'b0;
          if_done_d = (own_q == arb_own_if);
          dm_done_d = (own_q == arb_own_dm);
          state_d   = arb_sta_done;
        end else if (expire_w) begin
          mem_req_d = 1'b0;
          if_done_d = (own_q == arb_own_if);
          dm_done_d = (own_q == arb_own_dm);
          err_d     = 1'b1;
          state_d   = arb_sta_done;
        end
      end
      arb_sta_done: begin
        last_d  = own_q;
        busy_d  = 1'b0;
        state_d = arb_sta_idle;
      end
      default: begin
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        state_d   = arb_sta_idle;
      end
    endcase
  end

  always_ff @(posedge clk_i_w) begin
    if (rst_i_w) begin
      state_q   <= arb_sta_idle;
      own_q     <= arb_own_if;
      last_q    <= arb_own_dm;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
      if_done_q <= if_done_d;
      dm_done_q <= dm_done_d;
      err_q     <= err_d;
    end
  end

  assign if_done_o_r  = if_done_q;
  assign dm_done_o_r  = dm_done_q;
  assign rdat_o_r     = rdat_q;
  assign busy_o_r     = busy_q;
  assign err_o_r      = err_q;
  assign mem_req_o_r  = mem_req_q;
  assign mem_addr_o_r = addr_q;
  assign mem_we_o_r   = we_q;
  assign mem_wdat_o_r = wdat_q;

endmodule
